// File: rtl/alu_reservation_station_if.sv
// Issue, result-broadcast and dispatch bundle of the ALU reservation station.
// master = surrounding core (issue stage, broadcast buses, ALU); slave = the station.
interface alu_reservation_station_if #(
    parameter int ROB_POS_W = 4,
    parameter int DATA_W    = 32
);
    logic                 issue_en;
    logic [ROB_POS_W-1:0] issue_rob_pos;
    logic [6:0]           issue_opcode;
    logic [2:0]           issue_funct3;
    logic                 issue_funct7;
    logic                 issue_rs1_rdy;
    logic [DATA_W-1:0]    issue_rs1_val;
    logic [ROB_POS_W-1:0] issue_rs1_tag;
    logic                 issue_rs2_rdy;
    logic [DATA_W-1:0]    issue_rs2_val;
    logic [ROB_POS_W-1:0] issue_rs2_tag;
    logic [DATA_W-1:0]    issue_imm;
    logic [DATA_W-1:0]    issue_pc;
    logic                 rs_full;

    logic                 alu_bc_en;
    logic [ROB_POS_W-1:0] alu_bc_rob_pos;
    logic [DATA_W-1:0]    alu_bc_val;
    logic                 lsb_bc_en;
    logic [ROB_POS_W-1:0] lsb_bc_rob_pos;
    logic [DATA_W-1:0]    lsb_bc_val;

    logic                 alu_en;
    logic [ROB_POS_W-1:0] alu_rob_pos;
    logic [6:0]           alu_opcode;
    logic [2:0]           alu_funct3;
    logic                 alu_funct7;
    logic [DATA_W-1:0]    alu_val1;
    logic [DATA_W-1:0]    alu_val2;
    logic [DATA_W-1:0]    alu_imm;
    logic [DATA_W-1:0]    alu_pc;

    modport master (
        output issue_en, issue_rob_pos, issue_opcode, issue_funct3, issue_funct7,
               issue_rs1_rdy, issue_rs1_val, issue_rs1_tag,
               issue_rs2_rdy, issue_rs2_val, issue_rs2_tag, issue_imm, issue_pc,
               alu_bc_en, alu_bc_rob_pos, alu_bc_val, lsb_bc_en, lsb_bc_rob_pos, lsb_bc_val,
        input  rs_full, alu_en, alu_rob_pos, alu_opcode, alu_funct3, alu_funct7,
               alu_val1, alu_val2, alu_imm, alu_pc
    );

    modport slave (
        input  issue_en, issue_rob_pos, issue_opcode, issue_funct3, issue_funct7,
               issue_rs1_rdy, issue_rs1_val, issue_rs1_tag,
               issue_rs2_rdy, issue_rs2_val, issue_rs2_tag, issue_imm, issue_pc,
               alu_bc_en, alu_bc_rob_pos, alu_bc_val, lsb_bc_en, lsb_bc_rob_pos, lsb_bc_val,
        output rs_full, alu_en, alu_rob_pos, alu_opcode, alu_funct3, alu_funct7,
               alu_val1, alu_val2, alu_imm, alu_pc
    );
endinterface

// File: rtl/alu_reservation_station.sv
// Tomasulo ALU reservation station: capture operands from ALU/LSB broadcasts, dispatch one ready entry per cycle.
// Optional RS_OLDEST_FIRST_EN: oldest ready entry wins select instead of lowest index.
module alu_reservation_station #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_POS_W = 4,
    parameter int DATA_W    = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic rollback,
    alu_reservation_station_if.slave bus
);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_SIZE-1:0]   r_busy;
    logic [RS_SIZE-1:0]   r_rs1_rdy;
    logic [RS_SIZE-1:0]   r_rs2_rdy;
    logic [RS_SIZE-1:0]   r_funct7;
    logic [DATA_W-1:0]    r_rs1_val [RS_SIZE];
    logic [DATA_W-1:0]    r_rs2_val [RS_SIZE];
    logic [ROB_POS_W-1:0] r_rs1_tag [RS_SIZE];
    logic [ROB_POS_W-1:0] r_rs2_tag [RS_SIZE];
    logic [ROB_POS_W-1:0] r_rob_pos [RS_SIZE];
    logic [6:0]           r_opcode  [RS_SIZE];
    logic [2:0]           r_funct3  [RS_SIZE];
    logic [DATA_W-1:0]    r_imm     [RS_SIZE];
    logic [DATA_W-1:0]    r_pc      [RS_SIZE];

    logic [CNT_W-1:0]     r_count;
    logic                 r_rs_full;
    logic                 r_alu_en;
    logic [ROB_POS_W-1:0] r_alu_rob_pos;
    logic [6:0]           r_alu_opcode;
    logic [2:0]           r_alu_funct3;
    logic                 r_alu_funct7;
    logic [DATA_W-1:0]    r_alu_val1;
    logic [DATA_W-1:0]    r_alu_val2;
    logic [DATA_W-1:0]    r_alu_imm;
    logic [DATA_W-1:0]    r_alu_pc;

    logic [RS_SIZE-1:0]   w_ready;
    logic [RS_SIZE-1:0]   w_rs1_rdy_wk;
    logic [RS_SIZE-1:0]   w_rs2_rdy_wk;
    logic [DATA_W-1:0]    w_rs1_val_wk [RS_SIZE];
    logic [DATA_W-1:0]    w_rs2_val_wk [RS_SIZE];

    // Per-entry wakeup: a waiting operand snoops both buses; ALU wins a double hit (tags are unique anyway).
    generate
        for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
            logic w_rs1_alu_hit, w_rs1_lsb_hit, w_rs2_alu_hit, w_rs2_lsb_hit;
            assign w_rs1_alu_hit = bus.alu_bc_en && (r_rs1_tag[gi] == bus.alu_bc_rob_pos);
            assign w_rs1_lsb_hit = bus.lsb_bc_en && (r_rs1_tag[gi] == bus.lsb_bc_rob_pos);
            assign w_rs2_alu_hit = bus.alu_bc_en && (r_rs2_tag[gi] == bus.alu_bc_rob_pos);
            assign w_rs2_lsb_hit = bus.lsb_bc_en && (r_rs2_tag[gi] == bus.lsb_bc_rob_pos);
            assign w_rs1_rdy_wk[gi] = r_rs1_rdy[gi] | w_rs1_alu_hit | w_rs1_lsb_hit;
            assign w_rs2_rdy_wk[gi] = r_rs2_rdy[gi] | w_rs2_alu_hit | w_rs2_lsb_hit;
            assign w_rs1_val_wk[gi] = r_rs1_rdy[gi] ? r_rs1_val[gi] :
                                      w_rs1_alu_hit ? bus.alu_bc_val :
                                      w_rs1_lsb_hit ? bus.lsb_bc_val : r_rs1_val[gi];
            assign w_rs2_val_wk[gi] = r_rs2_rdy[gi] ? r_rs2_val[gi] :
                                      w_rs2_alu_hit ? bus.alu_bc_val :
                                      w_rs2_lsb_hit ? bus.lsb_bc_val : r_rs2_val[gi];
            assign w_ready[gi] = r_busy[gi] & r_rs1_rdy[gi] & r_rs2_rdy[gi];
        end
    endgenerate

    // Same-cycle bypass for operands arriving together with the issue.
    logic w_iss_rs1_alu_hit, w_iss_rs1_lsb_hit, w_iss_rs2_alu_hit, w_iss_rs2_lsb_hit;
    logic w_iss_rs1_rdy, w_iss_rs2_rdy;
    logic [DATA_W-1:0] w_iss_rs1_val, w_iss_rs2_val;
    assign w_iss_rs1_alu_hit = bus.alu_bc_en && (bus.issue_rs1_tag == bus.alu_bc_rob_pos);
    assign w_iss_rs1_lsb_hit = bus.lsb_bc_en && (bus.issue_rs1_tag == bus.lsb_bc_rob_pos);
    assign w_iss_rs2_alu_hit = bus.alu_bc_en && (bus.issue_rs2_tag == bus.alu_bc_rob_pos);
    assign w_iss_rs2_lsb_hit = bus.lsb_bc_en && (bus.issue_rs2_tag == bus.lsb_bc_rob_pos);
    assign w_iss_rs1_rdy = bus.issue_rs1_rdy | w_iss_rs1_alu_hit | w_iss_rs1_lsb_hit;
    assign w_iss_rs2_rdy = bus.issue_rs2_rdy | w_iss_rs2_alu_hit | w_iss_rs2_lsb_hit;
    assign w_iss_rs1_val = bus.issue_rs1_rdy ? bus.issue_rs1_val :
                           w_iss_rs1_alu_hit ? bus.alu_bc_val :
                           w_iss_rs1_lsb_hit ? bus.lsb_bc_val : '0;
    assign w_iss_rs2_val = bus.issue_rs2_rdy ? bus.issue_rs2_val :
                           w_iss_rs2_alu_hit ? bus.alu_bc_val :
                           w_iss_rs2_lsb_hit ? bus.lsb_bc_val : '0;

    logic             w_free_found;
    logic [IDX_W-1:0] w_free_idx;
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    logic             w_issue_accept;
    logic             w_sel_valid;
    logic [IDX_W-1:0] w_sel_idx;
    assign w_issue_accept = bus.issue_en && w_free_found;

`ifdef RS_OLDEST_FIRST_EN
    logic [IDX_W-1:0] r_age [RS_SIZE];
    logic [IDX_W-1:0] w_sel_age;

    // Strictly-greater compare keeps the lowest index on equal ages.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        w_sel_age   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (w_ready[i] && (!w_sel_valid || r_age[i] > w_sel_age)) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = IDX_W'(i);
                w_sel_age   = r_age[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            for (int i = 0; i < RS_SIZE; i++) r_age[i] <= '0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (w_issue_accept && w_free_idx == IDX_W'(i))
                    r_age[i] <= '0;
                else if (r_busy[i] && !(w_sel_valid && w_sel_idx == IDX_W'(i)) && r_age[i] != '1)
                    r_age[i] <= r_age[i] + IDX_W'(1);
            end
        end
    end
`else
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end
`endif

    logic [CNT_W-1:0] w_count_next;
    logic             w_full_next;
    assign w_count_next = r_count + CNT_W'(w_issue_accept) - CNT_W'(w_sel_valid);
    // Flag asserts one entry early so the registered version still protects the next issue.
    assign w_full_next  = (w_count_next >= CNT_W'(RS_SIZE - 1));

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            r_busy        <= '0;
            r_count       <= '0;
            r_rs_full     <= 1'b0;
            r_alu_en      <= 1'b0;
            r_alu_rob_pos <= '0;
            r_alu_opcode  <= '0;
            r_alu_funct3  <= '0;
            r_alu_funct7  <= 1'b0;
            r_alu_val1    <= '0;
            r_alu_val2    <= '0;
            r_alu_imm     <= '0;
            r_alu_pc      <= '0;
        end else if (rdy) begin
            r_count   <= w_count_next;
            r_rs_full <= w_full_next;
            r_alu_en  <= w_sel_valid;
            if (w_sel_valid) begin
                r_alu_rob_pos <= r_rob_pos[w_sel_idx];
                r_alu_opcode  <= r_opcode[w_sel_idx];
                r_alu_funct3  <= r_funct3[w_sel_idx];
                r_alu_funct7  <= r_funct7[w_sel_idx];
                r_alu_val1    <= r_rs1_val[w_sel_idx];
                r_alu_val2    <= r_rs2_val[w_sel_idx];
                r_alu_imm     <= r_imm[w_sel_idx];
                r_alu_pc      <= r_pc[w_sel_idx];
            end
            for (int i = 0; i < RS_SIZE; i++) begin
                if (w_sel_valid && w_sel_idx == IDX_W'(i)) begin
                    r_busy[i] <= 1'b0;
                end else if (w_issue_accept && w_free_idx == IDX_W'(i)) begin
                    r_busy[i]    <= 1'b1;
                    r_rob_pos[i] <= bus.issue_rob_pos;
                    r_opcode[i]  <= bus.issue_opcode;
                    r_funct3[i]  <= bus.issue_funct3;
                    r_funct7[i]  <= bus.issue_funct7;
                    r_imm[i]     <= bus.issue_imm;
                    r_pc[i]      <= bus.issue_pc;
                    r_rs1_rdy[i] <= w_iss_rs1_rdy;
                    r_rs1_val[i] <= w_iss_rs1_val;
                    r_rs1_tag[i] <= bus.issue_rs1_tag;
                    r_rs2_rdy[i] <= w_iss_rs2_rdy;
                    r_rs2_val[i] <= w_iss_rs2_val;
                    r_rs2_tag[i] <= bus.issue_rs2_tag;
                end else if (r_busy[i]) begin
                    r_rs1_rdy[i] <= w_rs1_rdy_wk[i];
                    r_rs1_val[i] <= w_rs1_val_wk[i];
                    r_rs2_rdy[i] <= w_rs2_rdy_wk[i];
                    r_rs2_val[i] <= w_rs2_val_wk[i];
                end
            end
        end
    end

    assign bus.rs_full     = r_rs_full;
    assign bus.alu_en      = r_alu_en;
    assign bus.alu_rob_pos = r_alu_rob_pos;
    assign bus.alu_opcode  = r_alu_opcode;
    assign bus.alu_funct3  = r_alu_funct3;
    assign bus.alu_funct7  = r_alu_funct7;
    assign bus.alu_val1    = r_alu_val1;
    assign bus.alu_val2    = r_alu_val2;
    assign bus.alu_imm     = r_alu_imm;
    assign bus.alu_pc      = r_alu_pc;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench: slot-level behavioural model compared every cycle, plus directed literal expectations.
module tb_alu_reservation_station;
    localparam logic [6:0] OP_CALC  = 7'b0110011;
    localparam logic [6:0] OP_CALCI = 7'b0010011;

    logic clk, rst, rdy, rollback;
    int   n_pass, n_total;
    bit   chk_on;

    alu_reservation_station_if #(.ROB_POS_W(4), .DATA_W(32)) bus ();

    alu_reservation_station #(.RS_SIZE(16), .ROB_POS_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        bit busy;
        bit r1; logic [31:0] v1; logic [3:0] t1;
        bit r2; logic [31:0] v2; logic [3:0] t2;
        logic [3:0] rob; logic [6:0] op; logic [2:0] f3; bit f7;
        logic [31:0] imm; logic [31:0] pc;
    } ent_t;

    ent_t         m_ent [16];
    bit           m_en, m_full;
    logic [159:0] m_pay;

    function automatic void wake(input bit rin, input logic [31:0] vin, input logic [3:0] tag,
                                 output bit rout, output logic [31:0] vout);
        rout = rin;
        vout = vin;
        if (!rin) begin
            if (bus.alu_bc_en && bus.alu_bc_rob_pos == tag) begin
                rout = 1'b1; vout = bus.alu_bc_val;
            end else if (bus.lsb_bc_en && bus.lsb_bc_rob_pos == tag) begin
                rout = 1'b1; vout = bus.lsb_bc_val;
            end
        end
    endfunction

    always @(posedge clk) begin
        int sel, fr, busy_cnt;
        ent_t e;
        if (rst || rollback) begin
            for (int i = 0; i < 16; i++) m_ent[i] = '0;
            m_en = 1'b0; m_full = 1'b0; m_pay = '0;
        end else if (rdy) begin
            sel = -1; fr = -1;
            for (int i = 0; i < 16; i++) begin
                if (sel < 0 && m_ent[i].busy && m_ent[i].r1 && m_ent[i].r2) sel = i;
                if (fr < 0 && !m_ent[i].busy) fr = i;
            end
            m_en = (sel >= 0);
            if (sel >= 0) begin
                e = m_ent[sel];
                m_pay = {17'b0, e.rob, e.op, e.f3, e.f7, e.v1, e.v2, e.imm, e.pc};
                m_ent[sel].busy = 1'b0;
            end
            for (int i = 0; i < 16; i++) begin
                if (m_ent[i].busy) begin
                    wake(m_ent[i].r1, m_ent[i].v1, m_ent[i].t1, m_ent[i].r1, m_ent[i].v1);
                    wake(m_ent[i].r2, m_ent[i].v2, m_ent[i].t2, m_ent[i].r2, m_ent[i].v2);
                end
            end
            if (bus.issue_en && fr >= 0) begin
                e = '0;
                e.busy = 1'b1;
                e.rob = bus.issue_rob_pos; e.op = bus.issue_opcode;
                e.f3 = bus.issue_funct3; e.f7 = bus.issue_funct7;
                e.imm = bus.issue_imm; e.pc = bus.issue_pc;
                e.t1 = bus.issue_rs1_tag; e.t2 = bus.issue_rs2_tag;
                wake(bus.issue_rs1_rdy, bus.issue_rs1_val, bus.issue_rs1_tag, e.r1, e.v1);
                wake(bus.issue_rs2_rdy, bus.issue_rs2_val, bus.issue_rs2_tag, e.r2, e.v2);
                m_ent[fr] = e;
            end
            busy_cnt = 0;
            for (int i = 0; i < 16; i++) busy_cnt += int'(m_ent[i].busy);
            m_full = (busy_cnt >= 15);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("alu_en", {159'b0, bus.alu_en}, {159'b0, m_en});
            check("rs_full", {159'b0, bus.rs_full}, {159'b0, m_full});
            check("payload", {17'b0, bus.alu_rob_pos, bus.alu_opcode, bus.alu_funct3, bus.alu_funct7,
                              bus.alu_val1, bus.alu_val2, bus.alu_imm, bus.alu_pc}, m_pay);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        bus.issue_en  = 1'b0;
        bus.alu_bc_en = 1'b0;
        bus.lsb_bc_en = 1'b0;
    endtask

    task automatic set_issue(input logic [3:0] rob, input logic [6:0] op, input logic [2:0] f3, input bit f7,
                             input bit r1, input logic [31:0] v1, input logic [3:0] t1,
                             input bit r2, input logic [31:0] v2, input logic [3:0] t2,
                             input logic [31:0] imm, input logic [31:0] pc);
        bus.issue_en = 1'b1;
        bus.issue_rob_pos = rob; bus.issue_opcode = op; bus.issue_funct3 = f3; bus.issue_funct7 = f7;
        bus.issue_rs1_rdy = r1; bus.issue_rs1_val = v1; bus.issue_rs1_tag = t1;
        bus.issue_rs2_rdy = r2; bus.issue_rs2_val = v2; bus.issue_rs2_tag = t2;
        bus.issue_imm = imm; bus.issue_pc = pc;
    endtask

    task automatic alu_bc(input logic [3:0] pos, input logic [31:0] val);
        bus.alu_bc_en = 1'b1; bus.alu_bc_rob_pos = pos; bus.alu_bc_val = val;
    endtask

    task automatic lsb_bc(input logic [3:0] pos, input logic [31:0] val);
        bus.lsb_bc_en = 1'b1; bus.lsb_bc_rob_pos = pos; bus.lsb_bc_val = val;
    endtask

    initial begin
        n_pass = 0; n_total = 0; chk_on = 1'b0;
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        bus.issue_en = 1'b0; bus.alu_bc_en = 1'b0; bus.lsb_bc_en = 1'b0;
        set_issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.issue_en = 1'b0;
        alu_bc(0, 0); lsb_bc(0, 0);
        bus.alu_bc_en = 1'b0; bus.lsb_bc_en = 1'b0;
        step(); step();
        chk_on = 1'b1;
        check("reset_alu_en", {159'b0, bus.alu_en}, 160'd0);
        check("reset_rs_full", {159'b0, bus.rs_full}, 160'd0);
        check("reset_rob_pos", {156'b0, bus.alu_rob_pos}, 160'd0);
        check("reset_val1", {128'b0, bus.alu_val1}, 160'd0);
        rst = 1'b0;

        // ADD, both operands ready
        set_issue(3, OP_CALC, 3'd0, 1'b0, 1, 5, 0, 1, 7, 0, 0, 32'h100);
        step();
        check("add_not_yet", {159'b0, bus.alu_en}, 160'd0);
        step();
        check("add_en", {159'b0, bus.alu_en}, 160'd1);
        check("add_rob", {156'b0, bus.alu_rob_pos}, 160'd3);
        check("add_val1", {128'b0, bus.alu_val1}, 160'd5);
        check("add_val2", {128'b0, bus.alu_val2}, 160'd7);
        step();
        check("add_pulse_end", {159'b0, bus.alu_en}, 160'd0);

        // SUB waiting on rs2 tag 6, woken two cycles later
        set_issue(4, OP_CALC, 3'd0, 1'b1, 1, 100, 0, 0, 0, 6, 0, 32'h104);
        step();
        check("sub_wait0", {159'b0, bus.alu_en}, 160'd0);
        step();
        alu_bc(6, 32'h10);
        step();
        check("sub_wait_bc", {159'b0, bus.alu_en}, 160'd0);
        step();
        check("sub_en", {159'b0, bus.alu_en}, 160'd1);
        check("sub_val2", {128'b0, bus.alu_val2}, 160'h10);
        check("sub_f7", {159'b0, bus.alu_funct7}, 160'd1);
        step();

        // Same-cycle LSB bypass on issue
        set_issue(5, OP_CALC, 3'd4, 1'b0, 0, 0, 2, 1, 3, 0, 0, 32'h108);
        lsb_bc(2, 32'hABCD);
        step();
        check("byp_wait", {159'b0, bus.alu_en}, 160'd0);
        step();
        check("byp_en", {159'b0, bus.alu_en}, 160'd1);
        check("byp_val1", {128'b0, bus.alu_val1}, 160'hABCD);
        step();

        // Back-to-back ready issues dispatch in order
        set_issue(8, OP_CALCI, 3'd1, 1'b0, 1, 1, 0, 1, 2, 0, 32'h20, 32'h10C);
        step();
        set_issue(9, OP_CALCI, 3'd2, 1'b0, 1, 3, 0, 1, 4, 0, 32'h30, 32'h110);
        step();
        check("b2b_first", {156'b0, bus.alu_rob_pos}, 160'd8);
        step();
        check("b2b_second", {156'b0, bus.alu_rob_pos}, 160'd9);
        check("b2b_imm", {128'b0, bus.alu_imm}, 160'h30);
        step(); step();

        // Fill 15 waiting entries -> rs_full
        for (int i = 0; i < 15; i++) begin
            set_issue(4'(i), OP_CALC, 3'd0, 1'b0, 0, 0, 4'(i), 1, 32'(i), 0, 0, 32'(32'h200 + 4 * i));
            step();
            if (i == 13) check("full_at_14", {159'b0, bus.rs_full}, 160'd0);
        end
        check("full_at_15", {159'b0, bus.rs_full}, 160'd1);
        alu_bc(7, 32'h77);
        step();
        check("full_wake_no_en", {159'b0, bus.alu_en}, 160'd0);
        check("full_still", {159'b0, bus.rs_full}, 160'd1);
        step();
        check("full_disp_en", {159'b0, bus.alu_en}, 160'd1);
        check("full_disp_rob", {156'b0, bus.alu_rob_pos}, 160'd7);
        check("full_disp_val1", {128'b0, bus.alu_val1}, 160'h77);
        check("full_drop", {159'b0, bus.rs_full}, 160'd0);

        // Rollback flushes everything
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        check("rb1_full", {159'b0, bus.rs_full}, 160'd0);
        check("rb1_payload", {128'b0, bus.alu_val1}, 160'd0);
        for (int i = 0; i < 8; i++) begin
            set_issue(4'(i), OP_CALC, 3'd0, 1'b0, 0, 0, 4'(i), 1, 1, 0, 0, 0);
            step();
        end
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        alu_bc(3, 32'h33);
        step();
        check("rb2_no_en_a", {159'b0, bus.alu_en}, 160'd0);
        step();
        check("rb2_no_en_b", {159'b0, bus.alu_en}, 160'd0);
        check("rb2_full", {159'b0, bus.rs_full}, 160'd0);
        set_issue(12, OP_CALC, 3'd7, 1'b0, 1, 32'h1234, 0, 1, 32'h5678, 0, 0, 32'h300);
        step();
        step();
        check("rb2_new_en", {159'b0, bus.alu_en}, 160'd1);
        check("rb2_new_rob", {156'b0, bus.alu_rob_pos}, 160'd12);
        step();

        // rdy low freezes the station
        set_issue(13, OP_CALC, 3'd5, 1'b1, 1, 32'h55, 0, 1, 32'h66, 0, 0, 32'h400);
        step();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_no_en", {159'b0, bus.alu_en}, 160'd0);
        end
        rdy = 1'b1;
        step();
        check("stall_en", {159'b0, bus.alu_en}, 160'd1);
        check("stall_rob", {156'b0, bus.alu_rob_pos}, 160'd13);
        check("stall_val1", {128'b0, bus.alu_val1}, 160'h55);
        check("stall_pc", {128'b0, bus.alu_pc}, 160'h400);
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station feeding the ALU in the Tomasulo core; sits directly upstream of the ALU.
- Accepts decoded ALU-class instructions (CALCU, CALCUI, BR, LUI, AUIPC, JAL, JALR) from the issue stage.
- Holds each instruction until both source operands are available, capturing values from the ALU and LSB broadcast buses.
- Dispatches one ready instruction per cycle to the ALU through a registered interface.

Parameters:
- RS_SIZE, 16, number of entries (power of two, ≥4)
- ROB_POS_W, 4, width of a ROB tag
- DATA_W, 32, operand/result width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; all state holds when low
- rollback  in  1  misprediction flush
- issue_en  in  1  enqueue request from issue stage
- issue_rob_pos  in  ROB_POS_W  destination ROB tag
- issue_opcode  in  7  opcode
- issue_funct3  in  3  funct3
- issue_funct7  in  1  funct7 bit 5
- issue_rs1_rdy  in  1  rs1 value valid
- issue_rs1_val  in  DATA_W  rs1 value when ready
- issue_rs1_tag  in  ROB_POS_W  producer tag when not ready
- issue_rs2_rdy, issue_rs2_val, issue_rs2_tag  in  1/DATA_W/ROB_POS_W  same for rs2
- issue_imm  in  DATA_W  immediate
- issue_pc  in  DATA_W  instruction PC
- rs_full  out  1  registered; issue stage must not assert issue_en next cycle
- alu_bc_en, alu_bc_rob_pos, alu_bc_val  in  1/ROB_POS_W/DATA_W  ALU result broadcast
- lsb_bc_en, lsb_bc_rob_pos, lsb_bc_val  in  1/ROB_POS_W/DATA_W  LSB result broadcast
- alu_en  out  1  dispatch valid (one-cycle pulse per instruction)
- alu_rob_pos, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_pc  out  registered dispatch payload

Behaviour:
- Reset, or rollback with rdy ignored: all entries invalid, count=0, rs_full=0, alu_en=0, all payload outputs 0.
- Reset/rollback take priority over any same-cycle issue, wakeup or dispatch.
- rdy=0: no state changes; outputs hold.
- Entry state: busy, rs1_rdy/val/tag, rs2_rdy/val/tag, rob_pos, opcode, funct3, funct7, imm, pc.

Issue:
- On issue_en, write to the lowest-index non-busy entry.
- If an operand is not ready and its tag matches a same-cycle alu_bc or lsb_bc, store the broadcast value as ready (bypass).
- issue_en while the station is genuinely full is a protocol violation; the request is dropped.

Wakeup:
- Each cycle, every busy entry compares each not-ready tag against both broadcast buses.
- On match, it latches the value and sets ready. When both buses match, either value is correct (tags are unique).

Select and dispatch:
- Ready = busy & rs1_rdy & rs2_rdy, evaluated on registered state.
- The lowest-index ready entry is dispatched: payload registered to the alu_* outputs, alu_en=1, entry freed in the same edge.
- No ready entry: alu_en=0, payload holds its last value.

Latency:
- Issue with both operands ready at edge T gives alu_en high after edge T+1.
- A broadcast wakeup at edge T gives dispatch after edge T+1 at earliest.

Occupancy and flags:
- count_next = count + issue − dispatch.
- rs_full_next = (count_next ≥ RS_SIZE−1), giving one cycle of slack for the registered flag.
- Simultaneous issue and dispatch in the same entry index is impossible: issue targets non-busy entries, dispatch targets busy ones.

Optional Feature:
- Macro: RS_OLDEST_FIRST_EN.
- Defined: each entry holds a log2(RS_SIZE)-bit age counter, cleared on issue and incremented per cycle while not dispatched (saturating). Select picks the ready entry with the largest age; ties go to the lowest index.
- Undefined: pure lowest-index priority, no age state.

Test Plan:
- Reset then issue ADD (rs1_rdy=1 val=5, rs2_rdy=1 val=7, rob_pos=3) -> next cycle alu_en=1, alu_rob_pos=3, alu_val1=5, alu_val2=7; following cycle alu_en=0.
- Issue SUB with rs2_rdy=0 tag=6; two cycles later alu_bc_en=1 pos=6 val=0x10 -> alu_en exactly one cycle after broadcast, alu_val2=0x10.
- Issue with rs1 tag=2 while lsb_bc_en=1 pos=2 val=0xABCD in the same cycle -> captured via bypass, dispatched next cycle with alu_val1=0xABCD.
- Issue 15 non-ready entries -> rs_full=1 after the 15th; one wakeup plus dispatch -> rs_full falls to 0 the cycle after.
- Fill 8 entries with pending operands, assert rollback -> alu_en stays 0 afterwards, rs_full=0, a new ready issue dispatches normally.
- Hold rdy=0 for 3 cycles with a ready entry -> no alu_en; raise rdy -> dispatch on the next edge with correct payload.
